// File: rtl/dbg_pkg.sv
// Shared encodings for the debug responder: command ops, target spaces, FSM states.
// Pure declarations, no logic; imported by the responder, its index map and benches.
// Encodings here are the wire-level values seen on cmd_op / cmd_space / dbg_space.
package dbg_pkg;

    // Command opcodes on cmd_op; 5..7 are rejected with rsp_err
    localparam logic [2:0] DBG_READ  = 3'd0;
    localparam logic [2:0] DBG_WRITE = 3'd1;
    localparam logic [2:0] DBG_HALT  = 3'd2;
    localparam logic [2:0] DBG_RUN   = 3'd3;
    localparam logic [2:0] DBG_STEP  = 3'd4;

    // Target spaces on cmd_space / dbg_space
    localparam logic [1:0] DBG_IMEM = 2'd0;
    localparam logic [1:0] DBG_DMEM = 2'd1;
    localparam logic [1:0] DBG_REG  = 2'd2;
    localparam logic [1:0] DBG_PC   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STEP1,
        ST_RESP
    } dbg_state_e;

    // Command as captured at the cmd handshake
    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  space;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dbg_cmd_t;

endpackage

// File: rtl/dbg_responder_if.sv
// Host-side command and response channels of the debug responder, valid/ready each.
// No logic, no latency.
// master = host (drives commands, accepts responses); slave = responder.
interface dbg_responder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_space;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_space, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_space, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dbg_index_map.sv
// Maps a debug space + host address to the word/register index of that target.
// Purely combinational, zero latency.
// No flow control; depths must be powers of two so the wrap is a mask.
module dbg_index_map
    import dbg_pkg::*;
#(
    parameter int IMEM_ROWS = 32,
    parameter int DMEM_ROWS = 32,
    parameter int REG_COUNT = 8
) (
    input  logic [1:0]  space_i,
    input  logic [31:0] addr_i,
    output logic [31:0] index_o
);

    localparam logic [31:0] IMASK = 32'(IMEM_ROWS - 1);
    localparam logic [31:0] DMASK = 32'(DMEM_ROWS - 1);
    localparam logic [31:0] RMASK = 32'(REG_COUNT - 1);

    // Memories are byte addressed (drop the low two bits); registers are indexed directly
    always_comb begin
        index_o = '0;
        case (space_i)
            DBG_IMEM: index_o = {2'b00, addr_i[31:2]} & IMASK;
            DBG_DMEM: index_o = {2'b00, addr_i[31:2]} & DMASK;
            DBG_REG:  index_o = addr_i & RMASK;
            default:  index_o = '0;
        endcase
    end

endmodule

// File: rtl/dbg_responder.sv
// Debug-port responder: host halt/run/step and read/write of IMEM, DMEM, REG and PC.
// Latency from cmd handshake to rsp_valid: READ 3, WRITE 1, HALT/RUN/illegal 0, STEP 1.
// One command in flight; cmd_ready low outside IDLE, response held until rsp_ready.
// Optional breakpoint register enabled by defining DBG_BREAKPOINT_EN.
module dbg_responder
    import dbg_pkg::*;
#(
    parameter int IMEM_ROWS = 32,
    parameter int DMEM_ROWS = 32,
    parameter int REG_COUNT = 8
) (
    input  logic            clk,
    input  logic            rst,
    dbg_responder_if.slave  bus,
    output logic            cpu_halt,
    output logic            dbg_en,
    output logic            dbg_we,
    output logic [1:0]      dbg_space,
    output logic [31:0]     dbg_index,
    output logic [31:0]     dbg_wdata,
    input  logic [31:0]     dbg_rdata,
    input  logic [31:0]     cpu_pc
);

    dbg_state_e  state_q;
    dbg_cmd_t    cmd_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        cpu_halt_q;
    logic        dbg_en_q;
    logic        dbg_we_q;
    logic        step_pend_q;   // re-halt owed after the single-step cycle

    logic        cmd_hs_d;
    logic        is_write_d;
    logic [31:0] rd_sel_d;

    assign cmd_hs_d   = bus.cmd_valid & cmd_ready_q;
    assign is_write_d = (cmd_q.op == DBG_WRITE);

`ifdef DBG_BREAKPOINT_EN
    logic [31:0] bp_addr_q;
    logic        bp_armed_q;
    logic        bp_hit_q;
    logic        bp_match_d;
    logic        bp_wr_d;
    logic        bp_rd_d;

    // Match only while running so a halted core parked on the address is not re-trapped
    assign bp_match_d = bp_armed_q & ~cpu_halt_q & (cpu_pc == bp_addr_q);
    assign bp_wr_d    = is_write_d  & (cmd_q.space == DBG_PC) & cmd_q.addr[0];
    assign bp_rd_d    = ~is_write_d & (cmd_q.space == DBG_PC) & cmd_q.addr[0];

    // Combinational term stalls the core in the very cycle the PC reaches the breakpoint
    assign cpu_halt = cpu_halt_q | bp_match_d;
`else
    assign cpu_halt = cpu_halt_q;
`endif

    // Read-data source: PC comes straight from the core, everything else from the target port
    always_comb begin
        rd_sel_d = dbg_rdata;
        if (cmd_q.space == DBG_PC) begin
            rd_sel_d = cpu_pc;
`ifdef DBG_BREAKPOINT_EN
            if (bp_rd_d) begin
                rd_sel_d = {31'b0, bp_hit_q};
            end
`endif
        end
    end

    dbg_index_map #(
        .IMEM_ROWS (IMEM_ROWS),
        .DMEM_ROWS (DMEM_ROWS),
        .REG_COUNT (REG_COUNT)
    ) u_index_map (
        .space_i (cmd_q.space),
        .addr_i  (cmd_q.addr),
        .index_o (dbg_index)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_en        = dbg_en_q;
    assign dbg_we        = dbg_we_q;
    assign dbg_space     = cmd_q.space;
    assign dbg_wdata     = cmd_q.wdata;

    // Command FSM with registered outputs; breakpoint trap applied last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cpu_halt_q  <= 1'b1;
            dbg_en_q    <= 1'b0;
            dbg_we_q    <= 1'b0;
            step_pend_q <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
            bp_addr_q   <= '0;
            bp_armed_q  <= 1'b0;
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_hs_d) begin
                        cmd_ready_q <= 1'b0;
                        cmd_q.op    <= bus.cmd_op;
                        cmd_q.space <= bus.cmd_space;
                        cmd_q.addr  <= bus.cmd_addr;
                        cmd_q.wdata <= bus.cmd_wdata;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        case (bus.cmd_op)
                            DBG_READ, DBG_WRITE: begin
                                state_q <= ST_ISSUE;
                            end
                            DBG_HALT: begin
                                cpu_halt_q  <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_RESP;
                            end
                            DBG_RUN: begin
                                cpu_halt_q  <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_RESP;
                            end
                            DBG_STEP: begin
                                state_q <= ST_STEP1;
                            end
                            default: begin
                                rsp_err_q   <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_RESP;
                            end
                        endcase
                    end
                end

                ST_ISSUE: begin
                    if (!cpu_halt_q) begin
                        // Target access is only safe while the core is frozen
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else
`ifdef DBG_BREAKPOINT_EN
                    if (bp_wr_d) begin
                        bp_addr_q   <= cmd_q.wdata;
                        bp_armed_q  <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else
`endif
                    begin
                        dbg_en_q <= 1'b1;
                        dbg_we_q <= is_write_d;
                        if (is_write_d) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (dbg_en_q) begin
                        // Strobe cycle: target registers its read data at this edge
                        dbg_en_q <= 1'b0;
                        dbg_we_q <= 1'b0;
                    end else begin
                        rsp_rdata_q <= rd_sel_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
`ifdef DBG_BREAKPOINT_EN
                        if (bp_rd_d) begin
                            bp_hit_q <= 1'b0;
                        end
`endif
                    end
                end

                ST_STEP1: begin
                    if (!cpu_halt_q) begin
                        rsp_err_q <= 1'b1;
                    end else begin
                        cpu_halt_q  <= 1'b0;
                        step_pend_q <= 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end

                ST_RESP: begin
                    dbg_en_q <= 1'b0;
                    dbg_we_q <= 1'b0;
                    if (step_pend_q) begin
                        cpu_halt_q  <= 1'b1;
                        step_pend_q <= 1'b0;
                    end
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

`ifdef DBG_BREAKPOINT_EN
            if (bp_match_d) begin
                cpu_halt_q <= 1'b1;
                bp_armed_q <= 1'b0;
                bp_hit_q   <= 1'b1;
            end
`endif
        end
    end

endmodule
